core_mem_unit: RTL

CORE_MEM_UNIT -- requirements
Module: core_mem_unit

---
 rtl/core_pkg.sv | 38 +++
 rtl/core_mem_align.sv | 60 ++++++
 rtl/core_mem_unit.sv | 122 ++++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// Shared core types: exec operand sources and memory access kinds,
// plus small decode helpers used by the memory unit.
package core_pkg;

  typedef enum logic [1:0] {
    EXEC_SRC_REG,
    EXEC_SRC_IMM,
    EXEC_SRC_PC,
    EXEC_SRC_MEM
  } exec_src_e;

  typedef enum logic [2:0] {
    MEM_LB,
    MEM_LH,
    MEM_LW,
    MEM_LBU,
    MEM_LHU,
    MEM_SB,
    MEM_SH,
    MEM_SW
  } mem_op_e;

  function automatic logic mem_is_store(input mem_op_e op);
    return (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
  endfunction

  function automatic logic mem_is_misaligned(input mem_op_e op, input logic [1:0] addr);
    logic mis;
    mis = 1'b0;
    case (op)
      MEM_LH, MEM_LHU, MEM_SH: mis = addr[0];
      MEM_LW, MEM_SW:          mis = (addr != 2'b00);
      default:                 mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/core_mem_align.sv
// Combinational lane steering: store strobes/replicated write data and
// load byte/half extraction with sign or zero extension.
module core_mem_align
  import core_pkg::*;
(
  input  mem_op_e     i_op,
  input  logic [1:0]  i_addr,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_wstrb,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
    o_wstrb = 4'b0000;
    o_wdata = i_wdata;
    case (i_op)
      MEM_SB: begin
        o_wstrb = 4'b0001 << i_addr;
        o_wdata = {4{i_wdata[7:0]}};
      end
      MEM_SH: begin
        o_wstrb = 4'b0011 << {i_addr[1], 1'b0};
        o_wdata = {2{i_wdata[15:0]}};
      end
      MEM_SW:  o_wstrb = 4'b1111;
      default: o_wstrb = 4'b0000;
    endcase
  end

  always_comb begin
    w_byte = i_rdata[7:0];
    case (i_addr)
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      2'd3:    w_byte = i_rdata[31:24];
      default: w_byte = i_rdata[7:0];
    endcase
  end

  // Misaligned halves fall back to the aligned half selected by addr[1].
  assign w_half = i_addr[1] ? i_rdata[31:16] : i_rdata[15:0];

  always_comb begin
    o_rdata = i_rdata;
    case (i_op)
      MEM_LB:  o_rdata = {{24{w_byte[7]}}, w_byte};
      MEM_LBU: o_rdata = {24'h0, w_byte};
      MEM_LH:  o_rdata = {{16{w_half[15]}}, w_half};
      MEM_LHU: o_rdata = {16'h0, w_half};
      default: o_rdata = i_rdata;
    endcase
  end

endmodule

// File: rtl/core_mem_unit.sv
// Load/store unit: one access at a time over a req/gnt/rvalid data bus.
// Optional CORE_MEM_MISALIGN_TRAP_EN completes misaligned accesses without a bus request.
module core_mem_unit
  import core_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_start,
  input  mem_op_e     mem_op,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic        mem_done,
  output logic        mem_busy,
  output logic [31:0] mem_rdata,
  output logic [31:0] mem_last_rdata,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [31:0] dbus_addr,
  output logic [3:0]  dbus_wstrb,
  output logic [31:0] dbus_wdata,
  input  logic        dbus_gnt,
  input  logic        dbus_rvalid,
  input  logic [31:0] dbus_rdata
`ifdef CORE_MEM_MISALIGN_TRAP_EN
  ,
  output logic        mem_misaligned
`endif
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
`ifdef CORE_MEM_MISALIGN_TRAP_EN
  localparam logic [1:0] S_TRAP = 2'd3;
`endif

  logic [1:0]  r_state;
  mem_op_e     r_op;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_last_rdata;

  logic [1:0]  w_state_nxt;
  logic        w_accept;
  logic        w_trap;
  logic        w_done;
  logic [31:0] w_load_data;

  core_mem_align u_align (
    .i_op    (r_op),
    .i_addr  (r_addr[1:0]),
    .i_wdata (r_wdata),
    .i_rdata (dbus_rdata),
    .o_wstrb (dbus_wstrb),
    .o_wdata (dbus_wdata),
    .o_rdata (w_load_data)
  );

  assign w_accept = (r_state == S_IDLE) && mem_start;

`ifdef CORE_MEM_MISALIGN_TRAP_EN
  assign w_trap         = (r_state == S_TRAP);
  assign mem_misaligned = w_trap && !rst;
`else
  assign w_trap = 1'b0;
`endif

  // Completion is combinational on rvalid; reset suppresses it so an abandoned access never reports.
  assign w_done = !rst && (((r_state == S_REQ) && dbus_gnt && dbus_rvalid) ||
                           ((r_state == S_WAIT) && dbus_rvalid) ||
                           w_trap);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (mem_start) begin
          w_state_nxt = S_REQ;
`ifdef CORE_MEM_MISALIGN_TRAP_EN
          if (mem_is_misaligned(mem_op, mem_addr[1:0])) w_state_nxt = S_TRAP;
`endif
        end
      end
      S_REQ: begin
        if (dbus_gnt && dbus_rvalid) w_state_nxt = S_IDLE;
        else if (dbus_gnt)           w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (dbus_rvalid) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      r_state      <= S_IDLE;
      r_op         <= MEM_LB;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_last_rdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_op    <= mem_op;
        r_addr  <= mem_addr;
        r_wdata <= mem_wdata;
      end
      if (w_done && !w_trap && !mem_is_store(r_op)) r_last_rdata <= w_load_data;
    end
  end

  assign mem_done       = w_done;
  assign mem_busy       = (r_state != S_IDLE);
  assign mem_rdata      = w_load_data;
  assign mem_last_rdata = r_last_rdata;
  assign dbus_req       = (r_state == S_REQ);
  assign dbus_we        = mem_is_store(r_op);
  assign dbus_addr      = {r_addr[31:2], 2'b00};

endmodule
